// File: rtl/crossbar_output_arbiter.sv
// Round-robin arbiter and zero-latency data mux for one crossbar output port.
// Optional burst abort on a stalled owner is enabled by defining ARB_TIMEOUT_EN.
module crossbar_output_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          in_req,
  input  logic [N_PORTS-1:0]          in_valid,
  input  logic [N_PORTS*DW-1:0]       in_data,
  output logic [N_PORTS-1:0]          in_ready,
  output logic [N_PORTS-1:0]          grant,
  output logic                        mem_req,
  output logic                        out_valid,
  output logic [DW-1:0]               out_data,
  input  logic                        out_ready,
  output logic                        burst_done,
  output logic                        timeout_err,
  output logic                        dbg_state,
  output logic [$clog2(BURST_LEN):0]  dbg_beat_cnt
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = $clog2(BURST_LEN) + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   rr_ptr, owner, pick, owner_inc;
  logic [CW-1:0]   beat_cnt;
  logic            found, beat, last_beat, abort;

  // Handshake: a beat is in_valid[owner] & out_ready while in BURST; in_ready
  // mirrors out_ready for the owner only, so the source sees the same beat.

  // First requester at or after rr_ptr, wrapping past N_PORTS-1.
  always_comb begin
    int            sum;
    logic [PW-1:0] cand;
    found = 1'b0;
    pick  = '0;
    sum   = 0;
    cand  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      sum = int'(rr_ptr) + i;
      if (sum >= N_PORTS) sum = sum - N_PORTS;
      cand = PW'(sum);
      if (!found && in_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign owner_inc = (owner == PW'(N_PORTS - 1)) ? '0 : owner + PW'(1);
  assign beat      = (state == BURST) && in_valid[owner] && out_ready;
  assign last_beat = beat && (beat_cnt == CW'(BURST_LEN - 1));

  always_comb begin
    out_valid  = 1'b0;
    out_data   = '0;
    in_ready   = '0;
    burst_done = last_beat;
    if (state == BURST) begin
      out_valid       = in_valid[owner];
      out_data        = in_data[owner*DW +: DW];
      in_ready[owner] = out_ready;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = BURST;
      BURST:   if (last_beat || abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      mem_req  <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      if (state == IDLE) begin
        if (found) begin
          grant    <= {{(N_PORTS-1){1'b0}}, 1'b1} << pick;
          owner    <= pick;
          mem_req  <= 1'b1;
          beat_cnt <= '0;
        end
      end else if (last_beat || abort) begin
        grant    <= '0;
        rr_ptr   <= owner_inc;
        beat_cnt <= '0;
      end else if (beat) begin
        beat_cnt <= beat_cnt + CW'(1);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          timeout_q;

  assign abort = (state == BURST) && !beat && (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE || beat || abort) idle_cnt <= '0;
      else                                idle_cnt <= idle_cnt + TW'(1);
      if (abort) timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign dbg_state    = state;
  assign dbg_beat_cnt = beat_cnt;

endmodule

// File: tb/tb_crossbar_output_arbiter.sv
// Directed bench for crossbar_output_arbiter: a vector table for a single
// burst plus hand-written sequences for reset, rotation, stall, drop, timeout.
module tb_crossbar_output_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_req, in_valid, in_ready, grant;
  logic [31:0] in_data;
  logic        mem_req, out_valid, out_ready, burst_done, timeout_err;
  logic [7:0]  out_data;
  logic        dbg_state;
  logic [2:0]  dbg_beat_cnt;

  crossbar_output_arbiter dut (
    .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .grant(grant), .mem_req(mem_req),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .burst_done(burst_done), .timeout_err(timeout_err),
    .dbg_state(dbg_state), .dbg_beat_cnt(dbg_beat_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic exp_terr = 1'b0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  e_grant;
    logic        e_memreq;
    logic        e_ovalid;
    logic [7:0]  e_odata;
    logic [3:0]  e_irdy;
    logic        e_done;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] v, input logic [31:0] d, input logic o);
    in_req    = r;
    in_valid  = v;
    in_data   = d;
    out_ready = o;
  endtask

  // Inputs are driven at posedge+1; outputs are sampled at the following negedge.
  task automatic chk_cycle(input string tag, input logic [3:0] g, input logic mr,
                           input logic ov, input logic [7:0] od, input logic [3:0] ir,
                           input logic bd);
    #4;
    check($sformatf("%s grant", tag), 32'(grant), 32'(g));
    check($sformatf("%s mem_req", tag), 32'(mem_req), 32'(mr));
    check($sformatf("%s out_valid", tag), 32'(out_valid), 32'(ov));
    if (ov) check($sformatf("%s out_data", tag), 32'(out_data), 32'(od));
    check($sformatf("%s in_ready", tag), 32'(in_ready), 32'(ir));
    check($sformatf("%s burst_done", tag), 32'(burst_done), 32'(bd));
    check($sformatf("%s timeout_err", tag), 32'(timeout_err), 32'(exp_terr));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    check($sformatf("%s grant", tag), 32'(grant), 0);
    check($sformatf("%s mem_req", tag), 32'(mem_req), 0);
    check($sformatf("%s out_valid", tag), 32'(out_valid), 0);
    check($sformatf("%s in_ready", tag), 32'(in_ready), 0);
    check($sformatf("%s burst_done", tag), 32'(burst_done), 0);
    check($sformatf("%s timeout_err", tag), 32'(timeout_err), 0);
    check($sformatf("%s state", tag), 32'(dbg_state), 0);
    check($sformatf("%s beat_cnt", tag), 32'(dbg_beat_cnt), 0);
  endtask

  function automatic logic [31:0] p2(input logic [7:0] x);
    return {8'h33, x, 8'h11, 8'h00};
  endfunction

  initial begin
    logic [3:0] g;
    logic [7:0] w;

    tbl[0] = '{4'b0100, 4'b0000, p2(8'h00), 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[1] = '{4'b0100, 4'b0100, p2(8'hA0), 1'b1, 4'b0100, 1'b1, 1'b1, 8'hA0, 4'b0100, 1'b0};
    tbl[2] = '{4'b0100, 4'b0100, p2(8'hA1), 1'b1, 4'b0100, 1'b0, 1'b1, 8'hA1, 4'b0100, 1'b0};
    tbl[3] = '{4'b0100, 4'b0100, p2(8'hA2), 1'b1, 4'b0100, 1'b0, 1'b1, 8'hA2, 4'b0100, 1'b0};
    tbl[4] = '{4'b0100, 4'b0100, p2(8'hA3), 1'b1, 4'b0100, 1'b0, 1'b1, 8'hA3, 4'b0100, 1'b1};
    tbl[5] = '{4'b0000, 4'b0000, p2(8'h00), 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[6] = '{4'b0000, 4'b0000, p2(8'h00), 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0};

    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single burst from port 2, in order, then back to idle.
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].req, tbl[i].valid, tbl[i].data, tbl[i].ordy);
      chk_cycle($sformatf("vec%0d", i), tbl[i].e_grant, tbl[i].e_memreq, tbl[i].e_ovalid,
                tbl[i].e_odata, tbl[i].e_irdy, tbl[i].e_done);
    end

    // rr_ptr is 3 now, so port 0 wins after wrap; reset lands mid-burst.
    drive(4'b0001, 4'b0001, 32'h0000_00D0, 1'b1);
    chk_cycle("wrap idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);
    chk_cycle("wrap b0", 4'b0001, 1'b1, 1'b1, 8'hD0, 4'b0001, 1'b0);
    drive(4'b0001, 4'b0001, 32'h0000_00D1, 1'b1);
    chk_cycle("wrap b1", 4'b0001, 1'b0, 1'b1, 8'hD1, 4'b0001, 1'b0);
    drive(4'b0001, 4'b0001, 32'h0000_00D2, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    chk_cycle("post rst0", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);
    chk_cycle("post rst1", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);

    // All four requesting: strict rotation, one idle cycle between bursts.
    drive(4'b1111, 4'b1111, 32'h4342_4140, 1'b1);
    for (int b = 0; b < 5; b++) begin
      g = 4'(1 << (b % 4));
      w = 8'(8'h40 + (b % 4));
      chk_cycle($sformatf("rr%0d idle", b), 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);
      for (int j = 0; j < 4; j++)
        chk_cycle($sformatf("rr%0d b%0d", b, j), g, (j == 0), 1'b1, w, g, (j == 3));
    end
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    chk_cycle("rr end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);

    // Port 1 stalled for 3 cycles after two beats.
    drive(4'b0010, 4'b0010, 32'h0000_B0EE, 1'b1);
    chk_cycle("stall idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);
    chk_cycle("stall b0", 4'b0010, 1'b1, 1'b1, 8'hB0, 4'b0010, 1'b0);
    drive(4'b0010, 4'b0010, 32'h0000_B1EE, 1'b1);
    chk_cycle("stall b1", 4'b0010, 1'b0, 1'b1, 8'hB1, 4'b0010, 1'b0);
    drive(4'b0010, 4'b0010, 32'h0000_B2EE, 1'b0);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("stall%0d beat_cnt", s), 32'(dbg_beat_cnt), 2);
      check($sformatf("stall%0d state", s), 32'(dbg_state), 1);
      chk_cycle($sformatf("stall%0d", s), 4'b0010, 1'b0, 1'b1, 8'hB2, 4'b0000, 1'b0);
    end
    out_ready = 1'b1;
    chk_cycle("stall b2", 4'b0010, 1'b0, 1'b1, 8'hB2, 4'b0010, 1'b0);
    drive(4'b0010, 4'b0010, 32'h0000_B3EE, 1'b1);
    chk_cycle("stall b3", 4'b0010, 1'b0, 1'b1, 8'hB3, 4'b0010, 1'b1);
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    chk_cycle("stall end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);

    // Port 3 drops in_req after its first beat; grant must hold.
    drive(4'b1000, 4'b1000, 32'hC000_0000, 1'b1);
    chk_cycle("drop idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);
    chk_cycle("drop b0", 4'b1000, 1'b1, 1'b1, 8'hC0, 4'b1000, 1'b0);
    for (int j = 1; j < 4; j++) begin
      w = 8'(8'hC0 + j);
      drive(4'b0000, 4'b1000, {w, 24'h0}, 1'b1);
      chk_cycle($sformatf("drop b%0d", j), 4'b1000, 1'b0, 1'b1, w, 4'b1000, (j == 3));
    end
    drive(4'b0000, 4'b0000, 32'h0, 1'b1);
    chk_cycle("drop end", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // Port 0 owns but never presents data: abort after 16 beatless cycles.
    drive(4'b0001, 4'b0000, 32'h0, 1'b1);
    chk_cycle("to idle", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);
    for (int c = 0; c < 16; c++)
      chk_cycle($sformatf("to c%0d", c), 4'b0001, (c == 0), 1'b0, 8'h00, 4'b0001, 1'b0);
    exp_terr = 1'b1;
    drive(4'b0011, 4'b0000, 32'h0, 1'b1);
    chk_cycle("to abort", 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0);
    chk_cycle("to regrant", 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0010, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
